hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV core; sits beside the forwarding unit and drives all

---
 rtl/hazard_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage RV core. Drives
//                every stall/flush enable of the IF/ID, ID/EX, EX/MEM and
//                MEM/WB pipeline registers. It covers the hazards that
//                forwarding cannot hide: load-use, a taken branch or jump
//                resolved in EX, and data-memory wait. It also sequences the
//                multi-cycle mul/div unit that sits in EX.
//  Ports       : clk, rst_n           clock, synchronous active-low reset
//                rs1_D/rs2_D/use_*_D  source operands of the ID instruction
//                rd_E/mem_read_E      destination of the EX instruction, load flag
//                branch_taken_E       PC redirect resolved in EX
//                md_op_E              EX instruction is a mul/div
//                dmem_req_M/ready_M   data-memory handshake of MEM
//                stall_F/D/E/M        hold PC / IF_ID / ID_EX / EX_MEM
//                flush_D/E/M/W        bubble into IF_ID / ID_EX / EX_MEM / MEM_WB
//                md_start/md_done     mul/div start pulse, result valid
//                timeout_err          sticky dmem-wait timeout flag
//                stall_cnt            saturating count of stall_F cycles
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_LATENCY    = 4,
    parameter int MWAIT_TIMEOUT = 255,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             mem_read_E,
    input  logic             branch_taken_E,
    input  logic             md_op_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             flush_W,
    output logic             md_start,
    output logic             md_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // The md counter only ever holds MD_LATENCY-1 down to 0.
    localparam int c_MD_W   = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    // The wait counter saturates at the timeout value, so it never needs more.
    localparam int c_WAIT_W = (MWAIT_TIMEOUT > 1) ? $clog2(MWAIT_TIMEOUT + 1) : 1;

    localparam logic [c_MD_W-1:0]   c_MD_INIT  = c_MD_W'(MD_LATENCY - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MWAIT_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MWAIT  = 2'd1,
        ST_MDBUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_MD_W-1:0]   r_mdCnt;
    logic [c_MD_W-1:0]   w_mdCntNext;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [c_WAIT_W-1:0] w_waitCntNext;
    logic                r_timeoutErr;
    logic                w_timeoutErrNext;
    logic [CNT_W-1:0]    r_stallCnt;

    logic w_memWait;
    logic w_loadUse;

    assign w_memWait = dmem_req_M & ~dmem_ready_M;
    assign w_loadUse = mem_read_E & (rd_E != 5'd0) &
                       ((use_rs1_D & (rs1_D == rd_E)) | (use_rs2_D & (rs2_D == rd_E)));

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        stall_F          = 1'b0;
        stall_D          = 1'b0;
        stall_E          = 1'b0;
        stall_M          = 1'b0;
        flush_D          = 1'b0;
        flush_E          = 1'b0;
        flush_M          = 1'b0;
        flush_W          = 1'b0;
        md_start         = 1'b0;
        md_done          = 1'b0;
        w_stateNext      = r_state;
        w_mdCntNext      = r_mdCnt;
        w_waitCntNext    = r_waitCnt;
        w_timeoutErrNext = r_timeoutErr;

        if (!rst_n) begin
            // Bubbles everywhere while held in reset; registers clear at the edge.
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
            flush_W = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN, ST_MWAIT: begin
                    // RUN and a released MWAIT share the same priority chain,
                    // so a branch held in EX during a freeze acts on release.
                    if (w_memWait) begin
                        // Freeze the front of the pipe; bubble WB so the
                        // instruction leaving MEM is not written back twice.
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        stall_E     = 1'b1;
                        stall_M     = 1'b1;
                        flush_W     = 1'b1;
                        w_stateNext = ST_MWAIT;
                        if (r_state == ST_RUN) begin
                            w_waitCntNext = c_WAIT_ONE;
                        end else if (r_waitCnt != c_WAIT_MAX) begin
                            w_waitCntNext = r_waitCnt + c_WAIT_ONE;
                        end
                        if (w_waitCntNext >= c_WAIT_MAX) begin
                            w_timeoutErrNext = 1'b1;
                        end
                    end else begin
                        w_waitCntNext = '0;
                        w_stateNext   = ST_RUN;
                        if (md_op_E) begin
                            md_start    = 1'b1;
                            stall_F     = 1'b1;
                            stall_D     = 1'b1;
                            stall_E     = 1'b1;
                            flush_M     = 1'b1;
                            w_stateNext = ST_MDBUSY;
                            w_mdCntNext = c_MD_INIT;
                        end else if (branch_taken_E) begin
                            // The ID instruction is squashed, so a load-use
                            // hit against it is irrelevant.
                            flush_D = 1'b1;
                            flush_E = 1'b1;
                        end else if (w_loadUse) begin
                            stall_F = 1'b1;
                            stall_D = 1'b1;
                            flush_E = 1'b1;
                        end
                    end
                end

                ST_MDBUSY: begin
                    // MEM only holds bubbles here, so mem_wait cannot arise.
                    if (r_mdCnt != '0) begin
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        stall_E     = 1'b1;
                        flush_M     = 1'b1;
                        w_mdCntNext = r_mdCnt - c_MD_W'(1);
                    end else begin
                        md_done     = 1'b1;
                        w_stateNext = ST_RUN;
                    end
                end

                default: begin
                    w_stateNext = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_mdCnt      <= '0;
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_mdCnt      <= w_mdCntNext;
            r_waitCnt    <= w_waitCntNext;
            r_timeoutErr <= w_timeoutErrNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (stall_F && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign timeout_err = r_timeoutErr;
    assign stall_cnt   = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances share the
//                stimulus: A with default parameters, B with a short wait
//                timeout and a 3-bit stall counter to reach saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int  c_MDL     = 4;
    localparam int  c_TO_A    = 255;
    localparam int  c_TO_B    = 2;
    localparam longint c_MAXA = 64'h0000_0000_FFFF_FFFF;
    localparam int  c_MAXB    = 7;

    // Output bit order: stall_F stall_D stall_E stall_M flush_D flush_E
    //                   flush_M flush_W md_start md_done
    localparam logic [9:0] c_IDLE  = 10'b0000000000;
    localparam logic [9:0] c_LU    = 10'b1100010000;
    localparam logic [9:0] c_BR    = 10'b0000110000;
    localparam logic [9:0] c_MDST  = 10'b1110001010;
    localparam logic [9:0] c_MDBSY = 10'b1110001000;
    localparam logic [9:0] c_MDDN  = 10'b0000000001;
    localparam logic [9:0] c_FRZ   = 10'b1111000100;
    localparam logic [9:0] c_RST   = 10'b0000111100;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rd_E;
    logic       use_rs1_D, use_rs2_D, mem_read_E, branch_taken_E, md_op_E;
    logic       dmem_req_M, dmem_ready_M;

    logic [9:0]  oA, oB;
    logic        errA, errB;
    logic [31:0] cntA;
    logic [2:0]  cntB;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MD_LATENCY(c_MDL), .MWAIT_TIMEOUT(c_TO_A), .CNT_W(32)) uA (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rd_E(rd_E), .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
        .md_op_E(md_op_E), .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .stall_F(oA[9]), .stall_D(oA[8]), .stall_E(oA[7]), .stall_M(oA[6]),
        .flush_D(oA[5]), .flush_E(oA[4]), .flush_M(oA[3]), .flush_W(oA[2]),
        .md_start(oA[1]), .md_done(oA[0]), .timeout_err(errA), .stall_cnt(cntA)
    );

    hazard_ctrl #(.MD_LATENCY(c_MDL), .MWAIT_TIMEOUT(c_TO_B), .CNT_W(3)) uB (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rd_E(rd_E), .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
        .md_op_E(md_op_E), .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .stall_F(oB[9]), .stall_D(oB[8]), .stall_E(oB[7]), .stall_M(oB[6]),
        .flush_D(oB[5]), .flush_E(oB[4]), .flush_M(oB[3]), .flush_W(oB[2]),
        .md_start(oB[1]), .md_done(oB[0]), .timeout_err(errB), .stall_cnt(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (behavioural) ----------------
    bit     mBusy;     // mul/div occupying EX
    int     mLeft;     // stall cycles still owed before the result is ready
    int     mRun;      // length of the current run of memory-wait freeze cycles
    bit     mErrA, mErrB;
    longint mCntA;
    int     mCntB;

    function automatic logic [9:0] expOut();
        logic lu;
        lu = mem_read_E && (rd_E != 0) &&
             ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));
        if (!rst_n)                          return c_RST;
        if (mBusy)                           return (mLeft > 0) ? c_MDBSY : c_MDDN;
        if (dmem_req_M && !dmem_ready_M)     return c_FRZ;
        if (md_op_E)                         return c_MDST;
        if (branch_taken_E)                  return c_BR;
        if (lu)                              return c_LU;
        return c_IDLE;
    endfunction

    task automatic modelReset();
        mBusy = 0; mLeft = 0; mRun = 0; mErrA = 0; mErrB = 0; mCntA = 0; mCntB = 0;
    endtask

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idleInputs();
        rs1_D = 0; rs2_D = 0; rd_E = 0; use_rs1_D = 0; use_rs2_D = 0;
        mem_read_E = 0; branch_taken_E = 0; md_op_E = 0;
        dmem_req_M = 0; dmem_ready_M = 0;
    endtask

    task automatic doReset();
        rst_n = 0;
        idleInputs();
        @(posedge clk); #1;
        rst_n = 1;
        modelReset();
    endtask

    // One model-checked cycle with the inputs currently applied.
    task automatic step();
        logic [9:0] e;
        #2;
        e = expOut();
        chk("outA", oA, e);
        chk("outB", oB, e);
        chk("errA", errA, mErrA);
        chk("errB", errB, mErrB);
        chk("cntA", cntA, mCntA);
        chk("cntB", cntB, mCntB);
        @(posedge clk); #1;
        if (!rst_n) begin
            modelReset();
        end else begin
            if (mBusy) begin
                if (mLeft > 0) mLeft--; else mBusy = 0;
            end else if (e[1]) begin
                mBusy = 1; mLeft = c_MDL - 1;
            end
            mRun = e[6] ? mRun + 1 : 0;
            if (mRun >= c_TO_A) mErrA = 1;
            if (mRun >= c_TO_B) mErrB = 1;
            if (e[9]) begin
                if (mCntA < c_MAXA) mCntA++;
                if (mCntB < c_MAXB) mCntB++;
            end
        end
    endtask

    // One cycle compared against a fixed expectation.
    task automatic expectCycle(string name, logic [9:0] exp);
        #2;
        chk(name, oA, exp);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, mrd, br, md, req, rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t tv[10];

    initial begin
        tv[0] = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_LU};
        tv[1] = '{5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE};
        tv[2] = '{5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE};
        tv[3] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c_BR};
        tv[4] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c_MDST};
        tv[5] = '{5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c_FRZ};
        tv[6] = '{5'd7, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c_LU};
        tv[7] = '{5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE};
        tv[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c_MDST};
        tv[9] = '{5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_IDLE};

        rst_n = 0;
        idleInputs();
        @(posedge clk); @(posedge clk); #1;
        #2;
        chk("rst_out", oA, c_RST);
        chk("rst_cnt", cntA, 0);
        chk("rst_err", errA, 0);
        doReset();

        // ---- table: single-cycle decode from RUN ----
        for (int i = 0; i < 10; i++) begin
            rs1_D = tv[i].rs1; rs2_D = tv[i].rs2; rd_E = tv[i].rd;
            use_rs1_D = tv[i].use1; use_rs2_D = tv[i].use2;
            mem_read_E = tv[i].mrd; branch_taken_E = tv[i].br; md_op_E = tv[i].md;
            dmem_req_M = tv[i].req; dmem_ready_M = tv[i].rdy;
            #2;
            chk($sformatf("vec%0d", i), oA, tv[i].exp);
            @(posedge clk); #1;
            doReset();
        end

        // ---- load-use bubble lasts one cycle ----
        rd_E = 5; mem_read_E = 1; rs2_D = 5; use_rs2_D = 1;
        expectCycle("lu_c0", c_LU);
        idleInputs();
        #2;
        chk("lu_c1", oA, c_IDLE);
        chk("lu_cnt", cntA, 1);
        doReset();

        // ---- mul/div sequence, md_op held to show it is not re-sampled ----
        md_op_E = 1;
        for (int i = 0; i < 5; i++)
            expectCycle($sformatf("md_c%0d", i), (i == 0) ? c_MDST : (i < 4) ? c_MDBSY : c_MDDN);
        md_op_E = 0;
        expectCycle("md_after", c_IDLE);
        chk("md_cnt", cntA, 4);
        doReset();

        // ---- 3-cycle memory wait, timeout on B only ----
        dmem_req_M = 1; dmem_ready_M = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_B", oB, c_FRZ);
            expectCycle("mw_A", c_FRZ);
        end
        dmem_ready_M = 1;
        rd_E = 3; mem_read_E = 1; rs1_D = 3; use_rs1_D = 1;
        expectCycle("mw_release", c_LU);
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        chk("mw_errA", errA, 0);
        chk("mw_errB", errB, 1);
        chk("mw_cntA", cntA, 4);
        chk("mw_cntB", cntB, 4);
        doReset();

        // ---- long wait saturates B's counter; branch acts on release ----
        dmem_req_M = 1; dmem_ready_M = 0; branch_taken_E = 1;
        repeat (10) expectCycle("lw", c_FRZ);
        dmem_ready_M = 1;
        expectCycle("lw_br", c_BR);
        idleInputs();
        #2;
        chk("lw_cntA", cntA, 10);
        chk("lw_cntB", cntB, 7);
        chk("lw_errB", errB, 1);
        doReset();

        // ---- reset in the middle of a mul/div ----
        md_op_E = 1;
        expectCycle("mr_c0", c_MDST);
        md_op_E = 0;
        expectCycle("mr_c1", c_MDBSY);
        rst_n = 0;
        expectCycle("mr_rst", c_RST);
        rst_n = 1;
        for (int i = 0; i < 5; i++) expectCycle("mr_idle", c_IDLE);
        chk("mr_cnt", cntA, 0);
        doReset();

        // ---- randomized run against the model ----
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 59) != 0);
            rs1_D          = 5'($urandom_range(0, 3));
            rs2_D          = 5'($urandom_range(0, 3));
            rd_E           = 5'($urandom_range(0, 3));
            use_rs1_D      = 1'($urandom_range(0, 1));
            use_rs2_D      = 1'($urandom_range(0, 1));
            mem_read_E     = ($urandom_range(0, 2) == 0);
            branch_taken_E = ($urandom_range(0, 4) == 0);
            md_op_E        = ($urandom_range(0, 7) == 0);
            dmem_req_M     = ($urandom_range(0, 2) == 0);
            dmem_ready_M   = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
